// File: rtl/sc_rowclear_pkg.sv
// ---------------------------------------------------------------------------
// sc_rowclear_pkg
// Shared definitions for the row-clear sequencer and the matrix display logic:
// matrix geometry, derived address and combo widths, the full-row constant and
// the sequencer state encoding.
// ---------------------------------------------------------------------------
package sc_rowclear_pkg;

   localparam int unsigned ROWS    = 8;
   localparam int unsigned COLS    = 8;
   localparam int unsigned SCORE_W = 8;

   // Row address width; kept at least 1 so a single-row matrix still builds
   localparam int unsigned ADDR_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

   // A pass clears at most ROWS rows, so the combo count needs to hold ROWS
   localparam int unsigned COMBO_W = $clog2(ROWS + 1);

   // Completely lit row word
   localparam logic [COLS-1:0] ROW_FULL = {COLS{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/sc_score_accum.sv
// ---------------------------------------------------------------------------
// sc_score_accum
// Saturating accumulator register. A clear request wins over an increment in
// the same cycle. Also intended for a future level counter.
//   clk_i      clock
//   rst_i      asynchronous active-high reset (value returns to 0)
//   clear_n_i  synchronous clear, active low, highest priority
//   inc_en_i   add inc_i on this edge
//   inc_i      increment amount
//   score_o    registered accumulated value, saturates at all ones
// ---------------------------------------------------------------------------
module sc_score_accum #(
   parameter int unsigned W     = 8,
   parameter int unsigned INC_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_n_i,
   input  logic             inc_en_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [W-1:0]     score_o
);

   localparam int unsigned SUM_W = W + 1;

   logic [SUM_W-1:0] sum_c;
   logic [W-1:0]     score_d;

   // Sum at one extra bit so the carry-out flags saturation
   always_comb begin
      sum_c   = {1'b0, score_o} + SUM_W'(inc_i);
      score_d = score_o;
      if (!clear_n_i) begin
         score_d = '0;
      end else if (inc_en_i) begin
         score_d = sum_c[W] ? {W{1'b1}} : sum_c[W-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         score_o <= '0;
      end else begin
         score_o <= score_d;
      end
   end

endmodule

// File: rtl/sc_rowclear_controller.sv
// ---------------------------------------------------------------------------
// sc_rowclear_controller
// Row-clear sequencer. On a start request it scans the matrix bank from the
// bottom row (ROWS-1) to the top (0). Each completely lit row is removed by
// strobing shift-down on it and every row above, one row per cycle, ending
// with a zero fill of row 0; the same address is then rescanned because a new
// row has dropped into it. Cleared rows add to a saturating score.
//
// Optional feature macro: SC_ROWCLEAR_COMBO_BONUS_EN
//   defined     : the n-th row cleared within one pass scores n
//   not defined : every cleared row scores 1 (no combo counter)
//
// Ports
//   SC_ROWCLEAR_CLOCK_50          system clock, rising edge
//   SC_ROWCLEAR_RESET_InHigh      asynchronous active-high reset
//   SC_ROWCLEAR_start_InLow       pass request, sampled only while idle
//   SC_ROWCLEAR_clearScore_InLow  synchronous score clear
//   SC_ROWCLEAR_rowData_In        bank word at rowAddr (combinational read)
//   SC_ROWCLEAR_rowAddr_Out       row address for read and shift
//   SC_ROWCLEAR_shiftRow_OutLow   shift-down strobe for the addressed row
//   SC_ROWCLEAR_busy_Out          high whenever a pass is in progress
//   SC_ROWCLEAR_done_OutLow       one-cycle low pulse closing a pass
//   SC_ROWCLEAR_score_Out         saturating cleared-row score
// ---------------------------------------------------------------------------
module sc_rowclear_controller
   import sc_rowclear_pkg::*;
(
   input  logic               SC_ROWCLEAR_CLOCK_50,
   input  logic               SC_ROWCLEAR_RESET_InHigh,
   input  logic               SC_ROWCLEAR_start_InLow,
   input  logic               SC_ROWCLEAR_clearScore_InLow,
   input  logic [COLS-1:0]    SC_ROWCLEAR_rowData_In,
   output logic [ADDR_W-1:0]  SC_ROWCLEAR_rowAddr_Out,
   output logic               SC_ROWCLEAR_shiftRow_OutLow,
   output logic               SC_ROWCLEAR_busy_Out,
   output logic               SC_ROWCLEAR_done_OutLow,
   output logic [SCORE_W-1:0] SC_ROWCLEAR_score_Out
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   scan_q, scan_d;
   logic [ADDR_W-1:0]   shift_q, shift_d;
   logic                row_full_c;
   logic                inc_en_c;
   logic [COMBO_W-1:0]  inc_c;

`ifdef SC_ROWCLEAR_COMBO_BONUS_EN
   logic [COMBO_W-1:0]  combo_q, combo_d;
`endif

   assign row_full_c = (SC_ROWCLEAR_rowData_In == ROW_FULL);

   // Score increment for the row whose clear completes this cycle
`ifdef SC_ROWCLEAR_COMBO_BONUS_EN
   assign inc_c = combo_q + COMBO_W'(1);
`else
   assign inc_c = COMBO_W'(1);
`endif

   // Next-state and pointer logic
   always_comb begin
      state_d  = state_q;
      scan_d   = scan_q;
      shift_d  = shift_q;
      inc_en_c = 1'b0;
`ifdef SC_ROWCLEAR_COMBO_BONUS_EN
      combo_d  = combo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!SC_ROWCLEAR_start_InLow) begin
               state_d = ST_SCAN;
               scan_d  = ADDR_W'(ROWS - 1);
`ifdef SC_ROWCLEAR_COMBO_BONUS_EN
               combo_d = '0;
`endif
            end
         end
         ST_SCAN: begin
            // rowAddr equals scan_q here, so rowData is the scanned row
            if (row_full_c) begin
               state_d = ST_SHIFT;
               shift_d = scan_q;
            end else if (scan_q == '0) begin
               state_d = ST_DONE;
            end else begin
               scan_d = scan_q - ADDR_W'(1);
            end
         end
         ST_SHIFT: begin
            if (shift_q != '0) begin
               shift_d = shift_q - ADDR_W'(1);
            end else begin
               // Row-0 zero fill is issued this cycle; rescan the same row
               state_d  = ST_SCAN;
               inc_en_c = 1'b1;
`ifdef SC_ROWCLEAR_COMBO_BONUS_EN
               combo_d  = combo_q + COMBO_W'(1);
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and pointer registers
   always_ff @(posedge SC_ROWCLEAR_CLOCK_50 or posedge SC_ROWCLEAR_RESET_InHigh) begin
      if (SC_ROWCLEAR_RESET_InHigh) begin
         state_q <= ST_IDLE;
         scan_q  <= '0;
         shift_q <= '0;
`ifdef SC_ROWCLEAR_COMBO_BONUS_EN
         combo_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         shift_q <= shift_d;
`ifdef SC_ROWCLEAR_COMBO_BONUS_EN
         combo_q <= combo_d;
`endif
      end
   end

   // Registered outputs, decoded from the upcoming state so they align with it
   always_ff @(posedge SC_ROWCLEAR_CLOCK_50 or posedge SC_ROWCLEAR_RESET_InHigh) begin
      if (SC_ROWCLEAR_RESET_InHigh) begin
         SC_ROWCLEAR_rowAddr_Out     <= '0;
         SC_ROWCLEAR_shiftRow_OutLow <= 1'b1;
         SC_ROWCLEAR_busy_Out        <= 1'b0;
         SC_ROWCLEAR_done_OutLow     <= 1'b1;
      end else begin
         SC_ROWCLEAR_shiftRow_OutLow <= (state_d != ST_SHIFT);
         SC_ROWCLEAR_busy_Out        <= (state_d != ST_IDLE);
         SC_ROWCLEAR_done_OutLow     <= (state_d != ST_DONE);
         case (state_d)
            ST_SCAN:  SC_ROWCLEAR_rowAddr_Out <= scan_d;
            ST_SHIFT: SC_ROWCLEAR_rowAddr_Out <= shift_d;
            default:  SC_ROWCLEAR_rowAddr_Out <= '0;
         endcase
      end
   end

   sc_score_accum #(
      .W     (SCORE_W),
      .INC_W (COMBO_W)
   ) u_score (
      .clk_i     (SC_ROWCLEAR_CLOCK_50),
      .rst_i     (SC_ROWCLEAR_RESET_InHigh),
      .clear_n_i (SC_ROWCLEAR_clearScore_InLow),
      .inc_en_i  (inc_en_c),
      .inc_i     (inc_c),
      .score_o   (SC_ROWCLEAR_score_Out)
   );

endmodule

// File: tb/tb_sc_rowclear_controller.sv
// ---------------------------------------------------------------------------
// tb_sc_rowclear_controller
// Bench for the row-clear sequencer. A behavioural matrix bank answers reads
// and applies shift strobes; a rule-level model predicts each pass (final
// matrix, clear count, strobe count, done cycle, score).
// ---------------------------------------------------------------------------
module tb_sc_rowclear_controller;
   import sc_rowclear_pkg::*;

`ifdef SC_ROWCLEAR_COMBO_BONUS_EN
   localparam bit COMBO_EN = 1'b1;
`else
   localparam bit COMBO_EN = 1'b0;
`endif
   localparam int SMAX = (1 << SCORE_W) - 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                start_n;
   logic                clr_n;
   logic [COLS-1:0]     row_data;
   logic [ADDR_W-1:0]   row_addr;
   logic                shift_n;
   logic                busy;
   logic                done_n;
   logic [SCORE_W-1:0]  score;

   logic [COLS-1:0]     bank     [ROWS];
   logic [COLS-1:0]     init_mat [ROWS];
   logic [COLS-1:0]     mdl      [ROWS];
   logic                load_req;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   int exp_score = 0;
   int exp_clears, exp_shifts, exp_done_cyc;
   int obs_shifts, obs_done_cyc, obs_busy_bad;
   int addr_log  [0:511];
   bit shift_log [0:511];

   always #5 clk = ~clk;

   sc_rowclear_controller dut (
      .SC_ROWCLEAR_CLOCK_50         (clk),
      .SC_ROWCLEAR_RESET_InHigh     (rst),
      .SC_ROWCLEAR_start_InLow      (start_n),
      .SC_ROWCLEAR_clearScore_InLow (clr_n),
      .SC_ROWCLEAR_rowData_In       (row_data),
      .SC_ROWCLEAR_rowAddr_Out      (row_addr),
      .SC_ROWCLEAR_shiftRow_OutLow  (shift_n),
      .SC_ROWCLEAR_busy_Out         (busy),
      .SC_ROWCLEAR_done_OutLow      (done_n),
      .SC_ROWCLEAR_score_Out        (score)
   );

   // Matrix bank: combinational read, shift-down on strobe, bulk load
   assign row_data = bank[row_addr];

   always @(posedge clk) begin
      if (load_req) begin
         for (int r = 0; r < ROWS; r++) bank[r] <= init_mat[r];
      end else if (!shift_n) begin
         bank[row_addr] <= (row_addr == '0) ? '0 : bank[row_addr - ADDR_W'(1)];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_matrix();
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
      for (int r = 0; r < ROWS; r++) mdl[r] = init_mat[r];
   endtask

   // Rule-level prediction of one pass over mdl
   task automatic model_pass();
      int p, cyc, combo, inc;
      p = ROWS - 1; cyc = 0; combo = 0;
      exp_clears = 0; exp_shifts = 0;
      forever begin
         if (mdl[p] == {COLS{1'b1}}) begin
            cyc        += p + 2;          // detecting scan + p+1 strobes
            exp_shifts += p + 1;
            for (int r = p; r > 0; r--) mdl[r] = mdl[r-1];
            mdl[0] = '0;
            combo++; exp_clears++;
            inc = COMBO_EN ? combo : 1;
            exp_score = (exp_score + inc > SMAX) ? SMAX : exp_score + inc;
         end else begin
            cyc += 1;
            if (p == 0) break;
            p--;
         end
      end
      exp_done_cyc = cyc + 1;
   endtask

   // Start a pass and observe it until done (bounded)
   task automatic run_pass(input bit hold_start, input bit clr_at_inc);
      obs_shifts = 0; obs_done_cyc = -1; obs_busy_bad = 0;
      @(negedge clk); start_n = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 400 && obs_done_cyc < 0; c++) begin
         @(negedge clk);
         if (!hold_start) start_n = 1'b1;
         clr_n = 1'b1;
         addr_log[c]  = int'(row_addr);
         shift_log[c] = ~shift_n;
         if (!busy) obs_busy_bad++;
         if (!shift_n) begin
            obs_shifts++;
            if (clr_at_inc && row_addr == '0) clr_n = 1'b0;
         end
         if (!done_n) begin
            obs_done_cyc = c;
            start_n = 1'b1;
         end
      end
      start_n = 1'b1;
      @(negedge clk);
      clr_n = 1'b1;
      check_val("busy_after_done", busy, 0);
      check_val("done_pulse_width", done_n, 1);
   endtask

   task automatic do_pass(input bit hold_start, input bit clr_at_inc);
      int bad;
      load_matrix();
      model_pass();
      if (clr_at_inc) exp_score = 0;
      run_pass(hold_start, clr_at_inc);
      check_val("done_cycle", obs_done_cyc, exp_done_cyc);
      check_val("shift_strobes", obs_shifts, exp_shifts);
      check_val("busy_gaps", obs_busy_bad, 0);
      check_val("score", score, exp_score);
      bad = 0;
      for (int r = 0; r < ROWS; r++) if (bank[r] !== mdl[r]) bad++;
      check_val("bank_rows_wrong", bad, 0);
   endtask

   task automatic fill(input logic [COLS-1:0] v);
      for (int r = 0; r < ROWS; r++) init_mat[r] = v;
   endtask

   initial begin
      rst = 1'b1; start_n = 1'b1; clr_n = 1'b1; load_req = 1'b0;
      fill('0);
      repeat (3) @(negedge clk);
      check_val("rst_addr", row_addr, 0);
      check_val("rst_shift", shift_n, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done_n, 1);
      check_val("rst_score", score, 0);
      rst = 1'b0;

      // Empty matrix: plain scan 7..0
      fill('0);
      do_pass(1'b0, 1'b0);
      for (int c = 1; c <= ROWS; c++) check_val("empty_scan_addr", addr_log[c], ROWS - c);

      // Bottom row full
      fill('0); init_mat[7] = 8'hFF;
      do_pass(1'b0, 1'b0);
      for (int c = 2; c <= 9; c++) begin
         check_val("r7_shift_addr", addr_log[c], 9 - c);
         check_val("r7_shift_strobe", shift_log[c], 1);
      end
      check_val("r7_rescan_addr", addr_log[10], 7);
      check_val("r7_row7_after", bank[7], 8'h00);

      // Two adjacent full rows with a partial row above
      fill('0); init_mat[7] = 8'hFF; init_mat[6] = 8'hFF; init_mat[5] = 8'h81;
      do_pass(1'b0, 1'b0);
      check_val("two_clear_row7", bank[7], 8'h81);

      // Drive the score up to saturation, then one more clear
      while (exp_score < SMAX) begin
         fill('1);
         do_pass(1'b0, 1'b0);
      end
      fill('0); init_mat[7] = 8'hFF;
      do_pass(1'b0, 1'b0);
      check_val("sat_hold", score, SMAX);

      // clearScore coinciding with the increment
      fill('0); init_mat[7] = 8'hFF;
      do_pass(1'b0, 1'b1);
      check_val("clear_beats_inc", score, 0);

      // start held low throughout: exactly one pass
      fill('0); init_mat[4] = 8'hFF; init_mat[7] = 8'h3C;
      do_pass(1'b1, 1'b0);
      repeat (4) begin
         @(negedge clk);
         check_val("hold_no_second_pass", busy, 0);
      end

      // Reset asserted while shifting
      fill('0); init_mat[7] = 8'hFF;
      load_matrix();
      @(negedge clk); start_n = 1'b0;
      @(posedge clk);
      @(negedge clk); start_n = 1'b1;
      for (int c = 0; c < 10 && shift_n; c++) @(negedge clk);
      check_val("reached_shift", shift_n, 0);
      rst = 1'b1; #1;
      check_val("midrst_addr", row_addr, 0);
      check_val("midrst_shift", shift_n, 1);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_done", done_n, 1);
      check_val("midrst_score", score, 0);
      exp_score = 0;
      @(negedge clk); rst = 1'b0;

      // Fully lit matrix must terminate with every row empty
      fill('1);
      do_pass(1'b0, 1'b0);
      check_val("full_clears", exp_clears, 8);

      // Randomised matrices
      repeat (8) begin
         for (int r = 0; r < ROWS; r++) begin
            case ($urandom_range(0, 3))
               0: init_mat[r] = '1;
               1: init_mat[r] = '0;
               2: init_mat[r] = COLS'($urandom);
               default: init_mat[r] = ~(COLS'(1) << $urandom_range(0, COLS - 1));
            endcase
         end
         do_pass(1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
